// File: rtl/uart_word_receiver.sv
// UART 8N1 receiver that packs four bytes (first byte in [31:24]) into a word
// and queues words in a first-word-fall-through FIFO with overrun/framing flags.
module uart_word_receiver #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_LOG    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [31:0] receiver_out,
  output logic        receiver_valid,
  input  logic        receiver_ready,
  output logic        framing_error,
  output logic        overrun,
  output logic [1:0]  dbg_state_o
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << FIFO_LOG;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   word_q;
  logic [31:0]   word_d;
  logic          fe_q;
  logic          rxd_meta_q, rxd_s_q, rxd_prev_q;

  logic                wr_en;
  logic                pop;
  logic                push;
  logic                byte_done;
  logic                full;
  logic [31:0]         mem_q [DEPTH];
  logic [FIFO_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG:0]   count_q;
  logic                overrun_q;

  // rxd is asynchronous; everything downstream uses rxd_s_q only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  assign byte_done = (state_q == STOP) && (cnt_q == CW'(CLK_PER_BIT - 1)) && rxd_s_q;
  assign push      = byte_done && (byte_cnt_q == 2'd3);

  always_comb begin
    word_d = word_q;
    case (byte_cnt_q)
      2'd0:    word_d[31:24] = shift_q;
      2'd1:    word_d[23:16] = shift_q;
      2'd2:    word_d[15:8]  = shift_q;
      default: word_d[7:0]   = shift_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      fe_q       <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Falling edge only, so a stop bit held low cannot retrigger
          if (rxd_prev_q && !rxd_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CW'(CLK_PER_BIT / 2 - 1)) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rxd_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CW'(CLK_PER_BIT - 1)) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxd_s_q;
            if (idx_q == 3'd7) state_q <= STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == CW'(CLK_PER_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rxd_s_q) begin
              word_q     <= word_d;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end else begin
              fe_q       <= 1'b1;
              byte_cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign framing_error = fe_q;
  assign dbg_state_o   = state_q;

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign full           = (count_q == (FIFO_LOG + 1)'(DEPTH));
  assign receiver_valid = (count_q != '0);
  assign pop            = receiver_valid && receiver_ready;
  assign wr_en          = push && (!full || pop);
  assign receiver_out   = mem_q[rd_ptr_q];
  assign overrun        = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_LOG'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_LOG'(1);
      if (wr_en && !pop)      count_q <= count_q + (FIFO_LOG + 1)'(1);
      else if (!wr_en && pop) count_q <= count_q - (FIFO_LOG + 1)'(1);
      if (push && !wr_en) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= word_d;
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver: serial byte driver, expected-word
// queue and a negedge monitor that checks every popped word.
module tb_uart_word_receiver;

  localparam int BIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [31:0] receiver_out;
  logic        receiver_valid;
  logic        receiver_ready = 1'b0;
  logic        framing_error;
  logic        overrun;
  logic [1:0]  dbg_state_o;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int fe0;

  uart_word_receiver #(.CLK_PER_BIT(BIT), .FIFO_LOG(2)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .receiver_out(receiver_out), .receiver_valid(receiver_valid),
    .receiver_ready(receiver_ready), .framing_error(framing_error),
    .overrun(overrun), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pulse_ready raises ready for exactly the cycle whose edge samples the stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input logic pulse_ready);
    rxd = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BIT);
    end
    rxd = stop_val;
    if (pulse_ready) begin
      tick(BIT - 2);
      receiver_ready = 1'b1;
      tick(1);
      receiver_ready = 1'b0;
      tick(1);
    end else begin
      tick(BIT);
    end
    rxd = 1'b1;
    tick(4);
  endtask

  task automatic send_word(input logic [31:0] w, input logic pulse_last);
    send_byte(w[31:24], 1'b1, 1'b0);
    send_byte(w[23:16], 1'b1, 1'b0);
    send_byte(w[15:8],  1'b1, 1'b0);
    send_byte(w[7:0],   1'b1, pulse_last);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick(1);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor_loop();
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && receiver_valid) valid_cycles++;
      if (rst_n && framing_error) fe_cnt++;
      if (rst_n && receiver_valid && receiver_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got %h expected none", receiver_out);
        end else begin
          exp = exp_q.pop_front();
          check("pop_word", receiver_out, exp);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    tick(3);
    check("rst_valid", 32'(receiver_valid), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // 1: single word, consumer always ready
    receiver_ready = 1'b1;
    valid_cycles = 0;
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678, 1'b0);
    wait_drain(50);
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);

    // 3: short low glitch on idle line
    fe0 = fe_cnt;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(20);
    check("t3_fe", 32'(fe_cnt), 32'(fe0));
    check("t3_valid", 32'(receiver_valid), 32'd0);

    // 4: framing error discards partial word
    fe0 = fe_cnt;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    exp_q.push_back(32'h11223344);
    send_word(32'h11223344, 1'b0);
    wait_drain(50);
    check("t4_fe_pulses", 32'(fe_cnt), 32'(fe0 + 1));

    // 2: fill with ready low, fifth word overruns
    receiver_ready = 1'b0;
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'h01234567);
    exp_q.push_back(32'h89ABCDEF);
    exp_q.push_back(32'h5A5AA5A5);
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'h01234567, 1'b0);
    send_word(32'h89ABCDEF, 1'b0);
    send_word(32'h5A5AA5A5, 1'b0);
    check("t2_overrun_before", 32'(overrun), 32'd0);
    send_word(32'hFFFF0000, 1'b0);
    check("t2_valid", 32'(receiver_valid), 32'd1);
    check("t2_head", receiver_out, 32'hCAFEF00D);
    check("t2_overrun", 32'(overrun), 32'd1);
    tick(3);
    check("t2_head_stable", receiver_out, 32'hCAFEF00D);
    receiver_ready = 1'b1;
    wait_drain(20);
    tick(2);
    check("t2_empty", 32'(receiver_valid), 32'd0);
    check("t2_overrun_sticky", 32'(overrun), 32'd1);

    // Reset clears the sticky overrun
    rst_n = 1'b0;
    tick(2);
    check("rst2_overrun", 32'(overrun), 32'd0);
    check("rst2_valid", 32'(receiver_valid), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // 5: push and pop in the same cycle while full
    receiver_ready = 1'b0;
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'h44444444);
    exp_q.push_back(32'h55555555);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_word(32'h44444444, 1'b0);
    send_word(32'h55555555, 1'b1);
    check("t5_overrun", 32'(overrun), 32'd0);
    check("t5_valid", 32'(receiver_valid), 32'd1);
    check("t5_head", receiver_out, 32'h22222222);
    check("t5_left", 32'(exp_q.size()), 32'd4);
    receiver_ready = 1'b1;
    wait_drain(20);
    tick(2);
    check("t5_empty", 32'(receiver_valid), 32'd0);

    // 6: reset in the middle of the second byte's data bits
    receiver_ready = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    rxd = 1'b0;
    tick(BIT);
    rxd = 1'b1;
    tick(3 * BIT);
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    check("t6_rst_valid", 32'(receiver_valid), 32'd0);
    check("t6_rst_fe", 32'(framing_error), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    check("t6_rst_state", 32'(dbg_state_o), 32'd0);
    rst_n = 1'b1;
    tick(4);
    receiver_ready = 1'b1;
    exp_q.push_back(32'h01020304);
    send_word(32'h01020304, 1'b0);
    wait_drain(50);
    tick(2);
    check("t6_empty", 32'(receiver_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
